// File: rtl/br_perf_monitor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// br_perf_monitor
//
// Consumes the branch-predictor probe outputs and accumulates performance
// statistics: saturating cycle/branch/miss counters, a sliding-window
// mispredict count over the last WIN_SIZE resolved branches, the PC of the
// most recent mispredict, and halt detection (HALT_INSN fetched for
// HALT_CYCLES consecutive cycles). A snapshot/acknowledge handshake exposes a
// coherent copy of the counters.
//
// Optional feature macro: BR_PERF_MONITOR_PRINT_EN
//   When defined, a simulation-only message reports cycles, branches, misses
//   and the per-mille miss rate on every RUN->HALTED transition.
//
// Ports:
//   clk_i, rst_i       clock; synchronous active-high reset
//   en_i               counting enable
//   br_instr_i         branch/jump resolved this cycle
//   br_miss_i          mispredict this cycle (qualified by br_instr_i)
//   instr_i            instruction currently fetched (halt detection)
//   t_instr_i          PC of the resolving branch
//   clear_i            zero live statistics, return to RUN
//   snap_req_i/ack_i   snapshot request / consume
//   snap_valid_o       snapshot registers hold a valid copy
//   snap_cyc/br/miss_o snapshot counter values
//   win_miss_o         mispredicts among the last WIN_SIZE branches (live)
//   last_miss_pc_o     PC of the most recent mispredict (live)
//   done_o             halt detected
//   err_o              sticky: br_miss_i seen without br_instr_i
// -----------------------------------------------------------------------------
module br_perf_monitor #(
   parameter int          CNT_W       = 32,
   parameter int          WIN_SIZE    = 16,
   parameter logic [31:0] HALT_INSN   = 32'h0000_006F,
   parameter int          HALT_CYCLES = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        en_i,
   input  logic                        br_instr_i,
   input  logic                        br_miss_i,
   input  logic [31:0]                 instr_i,
   input  logic [31:0]                 t_instr_i,
   input  logic                        clear_i,
   input  logic                        snap_req_i,
   input  logic                        snap_ack_i,
   output logic                        snap_valid_o,
   output logic [CNT_W-1:0]            snap_cyc_o,
   output logic [CNT_W-1:0]            snap_br_o,
   output logic [CNT_W-1:0]            snap_miss_o,
   output logic [$clog2(WIN_SIZE):0]   win_miss_o,
   output logic [31:0]                 last_miss_pc_o,
   output logic                        done_o,
   output logic                        err_o
);

   localparam int WM_W = $clog2(WIN_SIZE) + 1;
   localparam int RL_W = $clog2(HALT_CYCLES + 1);

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } state_e;

   state_e              state_q, state_d;
   logic [RL_W-1:0]     run_len_q, run_len_d;
   logic [CNT_W-1:0]    cyc_q, cyc_d;
   logic [CNT_W-1:0]    br_q, br_d;
   logic [CNT_W-1:0]    miss_q, miss_d;
   logic [WIN_SIZE-1:0] win_q, win_d;
   logic [WM_W-1:0]     win_miss_q, win_miss_d;
   logic [31:0]         last_pc_q, last_pc_d;
   logic                err_q, err_d;
   logic                snap_valid_q, snap_valid_d;
   logic [CNT_W-1:0]    snap_cyc_q, snap_cyc_d;
   logic [CNT_W-1:0]    snap_br_q, snap_br_d;
   logic [CNT_W-1:0]    snap_miss_q, snap_miss_d;

   logic count_en;
   logic br_ev;
   logic miss_ev;

   // Events in a clear cycle are dropped, and nothing counts once halted.
   assign count_en = (state_q == ST_RUN) && en_i && !clear_i;
   assign br_ev    = count_en && br_instr_i;
   assign miss_ev  = br_ev && br_miss_i;

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      run_len_d    = run_len_q;
      cyc_d        = cyc_q;
      br_d         = br_q;
      miss_d       = miss_q;
      win_d        = win_q;
      win_miss_d   = win_miss_q;
      last_pc_d    = last_pc_q;
      err_d        = err_q | (br_miss_i & ~br_instr_i);
      snap_valid_d = snap_valid_q;
      snap_cyc_d   = snap_cyc_q;
      snap_br_d    = snap_br_q;
      snap_miss_d  = snap_miss_q;

      if (clear_i) begin
         state_d    = ST_RUN;
         run_len_d  = '0;
         cyc_d      = '0;
         br_d       = '0;
         miss_d     = '0;
         win_d      = '0;
         win_miss_d = '0;
         last_pc_d  = '0;
      end else if (state_q == ST_RUN) begin
         if (instr_i == HALT_INSN) begin
            run_len_d = run_len_q + RL_W'(1);
            if (run_len_q == RL_W'(HALT_CYCLES - 1)) begin
               state_d = ST_HALTED;
            end
         end else begin
            run_len_d = '0;
         end

         // Counters stick at all-ones instead of wrapping.
         if (count_en && !(&cyc_q)) begin
            cyc_d = cyc_q + CNT_W'(1);
         end
         if (br_ev) begin
            if (!(&br_q)) begin
               br_d = br_q + CNT_W'(1);
            end
            // The window starts as zeros, so the bit falling out contributes
            // nothing until WIN_SIZE branches have been seen.
            win_d      = {win_q[WIN_SIZE-2:0], miss_ev};
            win_miss_d = win_miss_q + WM_W'(miss_ev) - WM_W'(win_q[WIN_SIZE-1]);
         end
         if (miss_ev) begin
            if (!(&miss_q)) begin
               miss_d = miss_q + CNT_W'(1);
            end
            last_pc_d = t_instr_i;
         end
      end

      // Snapshot captures the registered (pre-update, pre-clear) counters.
      if (snap_valid_q) begin
         if (snap_ack_i) begin
            snap_valid_d = 1'b0;
         end
      end else if (snap_req_i) begin
         snap_valid_d = 1'b1;
         snap_cyc_d   = cyc_q;
         snap_br_d    = br_q;
         snap_miss_d  = miss_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_RUN;
         run_len_q    <= '0;
         cyc_q        <= '0;
         br_q         <= '0;
         miss_q       <= '0;
         // NOTE: the window shift register must be reset, since win_miss_q
         // relies on it starting as all zeros.
         win_q        <= '0;
         win_miss_q   <= '0;
         last_pc_q    <= '0;
         err_q        <= 1'b0;
         snap_valid_q <= 1'b0;
         snap_cyc_q   <= '0;
         snap_br_q    <= '0;
         snap_miss_q  <= '0;
      end else begin
         state_q      <= state_d;
         run_len_q    <= run_len_d;
         cyc_q        <= cyc_d;
         br_q         <= br_d;
         miss_q       <= miss_d;
         win_q        <= win_d;
         win_miss_q   <= win_miss_d;
         last_pc_q    <= last_pc_d;
         err_q        <= err_d;
         snap_valid_q <= snap_valid_d;
         snap_cyc_q   <= snap_cyc_d;
         snap_br_q    <= snap_br_d;
         snap_miss_q  <= snap_miss_d;
      end
   end

   assign snap_valid_o   = snap_valid_q;
   assign snap_cyc_o     = snap_cyc_q;
   assign snap_br_o      = snap_br_q;
   assign snap_miss_o    = snap_miss_q;
   assign win_miss_o     = win_miss_q;
   assign last_miss_pc_o = last_pc_q;
   assign done_o         = (state_q == ST_HALTED);
   assign err_o          = err_q;

`ifdef BR_PERF_MONITOR_PRINT_EN
`ifndef SYNTHESIS
   function automatic longint unsigned per_mille(input logic [CNT_W-1:0] m,
                                                 input logic [CNT_W-1:0] b);
      if (b == '0) return 0;
      return (longint'(m) * 1000) / longint'(b);
   endfunction

   // Reports the statistics including the update of the halting cycle.
   always @(posedge clk_i) begin
      if (!rst_i && state_q == ST_RUN && state_d == ST_HALTED) begin
         $display("br_perf_monitor: halt cycles=%0d branches=%0d misses=%0d miss_rate=%0d/1000",
                  cyc_d, br_d, miss_d, per_mille(miss_d, br_d));
      end
   end
`endif
`endif

endmodule

// File: tb/tb_br_perf_monitor.sv
`timescale 1ns/1ps
// Directed self-checking bench for br_perf_monitor. A second instance with
// CNT_W=4 shares all stimulus except its snapshot handshake and is used to
// observe counter saturation.
module tb_br_perf_monitor;

   localparam logic [31:0] HALT = 32'h0000_006F;

   logic        clk_i = 1'b0;
   logic        rst_i, en_i, br_instr_i, br_miss_i, clear_i;
   logic        snap_req_i, snap_ack_i, snap_req4, snap_ack4;
   logic [31:0] instr_i, t_instr_i;

   logic        snap_valid_o, done_o, err_o;
   logic [31:0] snap_cyc_o, snap_br_o, snap_miss_o, last_miss_pc_o;
   logic [4:0]  win_miss_o;

   logic        snap_valid4, done4, err4;
   logic [3:0]  snap_cyc4, snap_br4, snap_miss4;
   logic [4:0]  win_miss4;
   logic [31:0] last_pc4;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   br_perf_monitor dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .br_instr_i(br_instr_i),
      .br_miss_i(br_miss_i), .instr_i(instr_i), .t_instr_i(t_instr_i),
      .clear_i(clear_i), .snap_req_i(snap_req_i), .snap_ack_i(snap_ack_i),
      .snap_valid_o(snap_valid_o), .snap_cyc_o(snap_cyc_o),
      .snap_br_o(snap_br_o), .snap_miss_o(snap_miss_o),
      .win_miss_o(win_miss_o), .last_miss_pc_o(last_miss_pc_o),
      .done_o(done_o), .err_o(err_o)
   );

   br_perf_monitor #(.CNT_W(4)) dut4 (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .br_instr_i(br_instr_i),
      .br_miss_i(br_miss_i), .instr_i(instr_i), .t_instr_i(t_instr_i),
      .clear_i(clear_i), .snap_req_i(snap_req4), .snap_ack_i(snap_ack4),
      .snap_valid_o(snap_valid4), .snap_cyc_o(snap_cyc4),
      .snap_br_o(snap_br4), .snap_miss_o(snap_miss4),
      .win_miss_o(win_miss4), .last_miss_pc_o(last_pc4),
      .done_o(done4), .err_o(err4)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1; en_i = 1'b0; br_instr_i = 1'b0; br_miss_i = 1'b0;
      clear_i = 1'b0; snap_req_i = 1'b0; snap_ack_i = 1'b0;
      snap_req4 = 1'b0; snap_ack4 = 1'b0; instr_i = 32'h0; t_instr_i = 32'h0;
      tick(2);
      rst_i = 1'b0;
   endtask

   initial begin
      // ---- reset state
      do_reset();
      check("rst_snap_valid", snap_valid_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err", err_o, 0);
      check("rst_win_miss", win_miss_o, 0);
      check("rst_last_pc", last_miss_pc_o, 0);
      check("rst_snap_cyc", snap_cyc_o, 0);

      // ---- 10 idle cycles then snapshot
      en_i = 1'b1;
      tick(10);
      snap_req_i = 1'b1;
      tick();
      snap_req_i = 1'b0;
      check("snap1_valid", snap_valid_o, 1);
      check("snap1_cyc", snap_cyc_o, 10);
      check("snap1_br", snap_br_o, 0);
      check("snap1_miss", snap_miss_o, 0);
      snap_req_i = 1'b1;             // ignored while valid
      tick(3);
      snap_req_i = 1'b0;
      check("snap1_hold_valid", snap_valid_o, 1);
      check("snap1_hold_cyc", snap_cyc_o, 10);
      snap_ack_i = 1'b1;
      tick();
      snap_ack_i = 1'b0;
      check("snap1_ack_drop", snap_valid_o, 0);

      // ---- 20 branches, every 4th mispredicted; CNT_W=4 instance saturates
      do_reset();
      en_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         br_instr_i = 1'b1;
         br_miss_i  = (i % 4 == 3);
         t_instr_i  = 32'h100 + 32'(4 * i);
         tick();
      end
      br_instr_i = 1'b0; br_miss_i = 1'b0;
      check("br_last_pc", last_miss_pc_o, 32'h14C);
      check("br_win_miss", win_miss_o, 4);
      check("br_win_miss_w4", win_miss4, 4);
      snap_req_i = 1'b1; snap_req4 = 1'b1;
      tick();
      snap_req_i = 1'b0; snap_req4 = 1'b0;
      check("br_snap_cyc", snap_cyc_o, 20);
      check("br_snap_br", snap_br_o, 20);
      check("br_snap_miss", snap_miss_o, 5);
      check("sat_snap_cyc", snap_cyc4, 15);
      check("sat_snap_br", snap_br4, 15);
      check("sat_snap_miss", snap_miss4, 5);
      snap_ack_i = 1'b1; snap_ack4 = 1'b1;
      tick();
      snap_ack_i = 1'b0; snap_ack4 = 1'b0;

      // ---- halt detection: 3 matches, break, 4 matches
      do_reset();
      en_i = 1'b1;
      instr_i = HALT;
      tick(3);
      instr_i = 32'h0000_0013;
      tick();
      check("halt_broken_run", done_o, 0);
      instr_i = HALT;
      tick(3);
      check("halt_after3", done_o, 0);
      tick();
      check("halt_after4", done_o, 1);
      br_instr_i = 1'b1; br_miss_i = 1'b1; t_instr_i = 32'h300;
      tick(3);
      br_instr_i = 1'b0; br_miss_i = 1'b0;
      check("halt_frozen_pc", last_miss_pc_o, 0);
      check("halt_frozen_win", win_miss_o, 0);
      snap_req_i = 1'b1;
      tick();
      snap_req_i = 1'b0;
      check("halt_snap_valid", snap_valid_o, 1);
      check("halt_snap_cyc", snap_cyc_o, 8);
      check("halt_snap_br", snap_br_o, 0);
      snap_ack_i = 1'b1;
      tick();
      snap_ack_i = 1'b0;
      instr_i = 32'h0;
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check("clear_done", done_o, 0);
      snap_req_i = 1'b1;
      tick();
      snap_req_i = 1'b0;
      check("clear_snap_cyc", snap_cyc_o, 0);
      snap_ack_i = 1'b1;
      tick();
      snap_ack_i = 1'b0;

      // ---- clear and snapshot in the same cycle
      do_reset();
      en_i = 1'b1;
      for (int i = 0; i < 7; i++) begin
         br_instr_i = 1'b1; br_miss_i = 1'b1;
         t_instr_i  = 32'h200 + 32'(4 * i);
         tick();
      end
      check("cs_win_miss_pre", win_miss_o, 7);
      check("cs_last_pc_pre", last_miss_pc_o, 32'h218);
      clear_i = 1'b1; snap_req_i = 1'b1; t_instr_i = 32'h400;
      tick();
      clear_i = 1'b0; snap_req_i = 1'b0; br_instr_i = 1'b0; br_miss_i = 1'b0;
      check("cs_snap_miss", snap_miss_o, 7);
      check("cs_snap_br", snap_br_o, 7);
      check("cs_snap_cyc", snap_cyc_o, 7);
      check("cs_win_miss_post", win_miss_o, 0);
      check("cs_last_pc_post", last_miss_pc_o, 0);
      snap_ack_i = 1'b1;
      tick();
      snap_ack_i = 1'b0;
      snap_req_i = 1'b1;
      tick();
      snap_req_i = 1'b0;
      check("cs_live_cyc", snap_cyc_o, 1);
      check("cs_live_br", snap_br_o, 0);
      check("cs_live_miss", snap_miss_o, 0);
      snap_ack_i = 1'b1;
      tick();
      snap_ack_i = 1'b0;

      // ---- miss without branch: sticky error, no count
      check("err_before", err_o, 0);
      br_miss_i = 1'b1; t_instr_i = 32'h500;
      tick();
      br_miss_i = 1'b0;
      check("err_set", err_o, 1);
      check("err_no_pc", last_miss_pc_o, 0);
      check("err_no_win", win_miss_o, 0);
      snap_req_i = 1'b1;
      tick();
      snap_req_i = 1'b0;
      check("err_snap_miss", snap_miss_o, 0);
      check("err_snap_br", snap_br_o, 0);
      snap_ack_i = 1'b1;
      tick();
      snap_ack_i = 1'b0;
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check("err_after_clear", err_o, 1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("err_after_rst", err_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/br_perf_monitor.md
Name: br_perf_monitor

Overview:
- Downstream consumer of the branch-predictor core wrapper's probe outputs: branch-resolve strobe, misprediction strobe, fetched instruction, resolving-branch PC.
- Accumulates saturating performance counters, a sliding-window misprediction count, the PC of the last mispredict, and detects program halt.
- Provides a snapshot/acknowledge readout so the bench can sample coherent statistics.

Parameters:
CNT_W, 32, width of cycle/branch/miss counters
WIN_SIZE, 16, sliding window depth in resolved branches; power of two, >=2
HALT_INSN, 32'h0000_006F, instruction encoding treated as halt (jal x0,0)
HALT_CYCLES, 4, consecutive cycles HALT_INSN must be fetched to declare halt; >=1

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
en_i  in  1  counting enable
br_instr_i  in  1  branch/jump resolved this cycle
br_miss_i  in  1  mispredict (flush) this cycle; qualified by br_instr_i
instr_i  in  32  instruction currently fetched
t_instr_i  in  32  PC of resolving branch
clear_i  in  1  zero live counters/window, leave HALTED
snap_req_i  in  1  request snapshot
snap_ack_i  in  1  snapshot consumed
snap_valid_o  out  1  snapshot registers valid
snap_cyc_o  out  CNT_W  snapshot cycle count
snap_br_o  out  CNT_W  snapshot branch count
snap_miss_o  out  CNT_W  snapshot miss count
win_miss_o  out  $clog2(WIN_SIZE)+1  mispredicts among last WIN_SIZE branches (live)
last_miss_pc_o  out  32  t_instr_i of most recent mispredict (live)
done_o  out  1  halt detected
err_o  out  1  sticky: br_miss_i seen without br_instr_i

Behaviour:
- Reset: all counters, window shift register, win_miss_o, last_miss_pc_o, snapshot regs, snap_valid_o, done_o, err_o = 0; FSM = RUN; halt run-length = 0.
- FSM: RUN -> HALTED when halt run-length reaches HALT_CYCLES; HALTED -> RUN only on clear_i. done_o = (state==HALTED), registered.
- Halt run-length (RUN only): increments when instr_i==HALT_INSN, else resets to 0. done_o rises on the cycle after the HALT_CYCLES-th consecutive match.
- Live counters update only in RUN with en_i=1; all updates are registered (visible next cycle):
  - cycle counter +1 every such cycle.
  - branch counter +1 when br_instr_i.
  - miss counter +1 when br_instr_i & br_miss_i; last_miss_pc_o <= t_instr_i.
- Saturation: each counter holds at all-ones; no wrap.
- br_miss_i & !br_instr_i: event ignored, err_o set (sets in any state and regardless of en_i); err_o is cleared only by rst_i.
- Window:
  - On each counted branch, shift in the miss bit and drop the oldest bit.
  - win_miss_o += in - out. The unfilled window holds zeros, so out=0 until WIN_SIZE branches have been seen.
  - Range 0..WIN_SIZE.
- clear_i (any state): next cycle, live counters, window, win_miss_o, last_miss_pc_o and halt run-length = 0; state = RUN. Events in the same cycle as clear_i are dropped. Snapshot regs and err_o are unaffected.
- Snapshot handshake:
  - snap_req_i while !snap_valid_o: next cycle, snap_* load the live counter values as they stand before that cycle's update (pre-clear if clear_i is simultaneous); snap_valid_o=1.
  - snap_valid_o and snap_* hold until snap_ack_i; snap_valid_o drops the cycle after snap_ack_i.
  - snap_req_i while snap_valid_o is ignored, including in the ack cycle.
  - snap_ack_i while !snap_valid_o is ignored.
  - Snapshots are allowed in HALTED.
- rst_i mid-operation overrides everything, including a pending snapshot.

Optional Feature:
- Macro BR_PERF_MONITOR_PRINT_EN.
- Defined: on each RUN->HALTED transition, simulation-only $display of cycles, branches, misses, and miss rate in per-mille (misses*1000/branches, 0 if branches==0). The print block is excluded from synthesis.
- Undefined: no prints; RTL is otherwise identical.

Test Plan:
- Reset, then en_i=1 for 10 idle cycles, snap_req_i pulse -> snap_valid_o=1 next cycle, snap_cyc_o=10, snap_br_o=0, snap_miss_o=0; held until snap_ack_i, then snap_valid_o=0 next cycle.
- 20 branches (br_instr_i), every 4th with br_miss_i, t_instr_i=0x100+4*i -> branch count=20, miss count=5, last_miss_pc_o=0x14C, win_miss_o=4 (WIN_SIZE=16).
- CNT_W=4, 20 enabled cycles -> cycle counter saturates at 15; snapshot shows 15.
- instr_i=HALT_INSN for 3 cycles, a different instruction, then 4 cycles of HALT_INSN -> done_o rises only after the 4-cycle run; counters frozen afterwards; clear_i -> done_o=0, counters 0.
- clear_i and snap_req_i same cycle with miss count=7 -> snap_miss_o=7, live miss count=0; simultaneous br_instr_i/br_miss_i not counted.
- br_miss_i=1 with br_instr_i=0 -> err_o=1 sticky, miss count unchanged; clear_i does not clear err_o; rst_i does.
